// File: rtl/cdb_arbiter.sv
// -----------------------------------------------------------------------------
// cdb_arbiter
//   Selects up to NUM_GRANT completed reservation stations per cycle to drive
//   the common data buses. Selection is fixed priority (ARB_MODE=0) or round
//   robin (ARB_MODE=1). A requester that has waited STARVE_LIMIT cycles takes
//   precedence over the normal rule. Grants are suppressed while the forwarding
//   path claims the bus, and for RESP_DELAY cycles after each LSQ response.
//
// Ports
//   clk            clock
//   rst_n          asynchronous active-low reset; forces all outputs to 0
//   complete_i     [NUM_REQ]   station i has a result ready
//   resp_i         LSQ memory response this cycle (opens blackout window)
//   forward_i      bus claimed by forwarding path; no grants this cycle
//   grant_valid_o  [NUM_GRANT] slot k holds a valid grant (packed from slot 0)
//   grant_idx_o    [NUM_GRANT][IDX_W] granted station per slot, 0 when invalid
//   load_o         equals grant_valid_o[0]
//
// Optional feature (macro CDB_ARB_STATS_EN), saturating counters:
//   stat_grants_o        [32] total grants issued
//   stat_block_cycles_o  [32] cycles blocked while some station was complete
//   stat_starve_o        [16] cycles where slot 0 was a starvation override
// -----------------------------------------------------------------------------
`ifndef NUM_STATIONS
`define NUM_STATIONS 8
`endif

module cdb_arbiter #(
  parameter int NUM_REQ      = `NUM_STATIONS,
  parameter int NUM_GRANT    = 2,
  parameter int ARB_MODE     = 1,
  parameter int STARVE_LIMIT = 7,
  parameter int RESP_DELAY   = 1,
  parameter int IDX_W        = (NUM_REQ > 2) ? $clog2(NUM_REQ) : 1
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic [NUM_REQ-1:0]              complete_i,
  input  logic                            resp_i,
  input  logic                            forward_i,
  output logic [NUM_GRANT-1:0]            grant_valid_o,
  output logic [NUM_GRANT-1:0][IDX_W-1:0] grant_idx_o,
  output logic                            load_o
`ifdef CDB_ARB_STATS_EN
  ,
  output logic [31:0]                     stat_grants_o,
  output logic [31:0]                     stat_block_cycles_o,
  output logic [15:0]                     stat_starve_o
`endif
);

  localparam int BLK_W = (RESP_DELAY > 0) ? $clog2(RESP_DELAY + 1) : 1;
  localparam int AGE_W = $clog2(STARVE_LIMIT + 1);

  logic [IDX_W-1:0]              rr_q, rr_d;
  logic [BLK_W-1:0]              blk_q, blk_d;
  logic [NUM_REQ-1:0][AGE_W-1:0] age_q, age_d;

  logic                          blocked;
  logic [NUM_REQ-1:0]            starved;
  logic [NUM_REQ-1:0]            granted;
  logic [NUM_GRANT-1:0]          gv;
  logic [NUM_GRANT-1:0][IDX_W-1:0] gi;
  logic                          slot0_starve;

  assign blocked = forward_i | (blk_q != '0);

  always_comb begin
    for (int i = 0; i < NUM_REQ; i++) begin
      starved[i] = complete_i[i] & (age_q[i] == AGE_W'(STARVE_LIMIT));
    end
  end

  // Each slot repeats the same search over the stations not yet granted, so a
  // failed slot implies every later slot fails too and grants stay packed.
  always_comb begin
    logic found;
    int   sel;
    int   j;
    gv           = '0;
    gi           = '0;
    granted      = '0;
    slot0_starve = 1'b0;
    found        = 1'b0;
    sel          = 0;
    j            = 0;
    if (!blocked) begin
      for (int k = 0; k < NUM_GRANT; k++) begin
        found = 1'b0;
        sel   = 0;
        for (int i = 0; i < NUM_REQ; i++) begin
          if (!found && starved[i] && !granted[i]) begin
            found = 1'b1;
            sel   = i;
          end
        end
        if (found && (k == 0)) slot0_starve = 1'b1;
        if (!found) begin
          if (ARB_MODE == 0) begin
            for (int i = 0; i < NUM_REQ; i++) begin
              if (!found && complete_i[i] && !granted[i]) begin
                found = 1'b1;
                sel   = i;
              end
            end
          end else begin
            for (int off = 0; off < NUM_REQ; off++) begin
              j = int'(rr_q) + off;
              if (j >= NUM_REQ) j = j - NUM_REQ;
              if (!found && complete_i[j] && !granted[j]) begin
                found = 1'b1;
                sel   = j;
              end
            end
          end
        end
        if (found) begin
          gv[k]        = 1'b1;
          gi[k]        = IDX_W'(sel);
          granted[sel] = 1'b1;
        end
      end
    end
  end

  // Next state: pointer follows the highest valid slot; blackout counter
  // reloads on every response so back-to-back responses extend the window.
  always_comb begin
    rr_d = rr_q;
    if (ARB_MODE != 0) begin
      for (int k = 0; k < NUM_GRANT; k++) begin
        if (gv[k]) rr_d = (gi[k] == IDX_W'(NUM_REQ - 1)) ? '0 : gi[k] + 1'b1;
      end
    end

    if ((RESP_DELAY > 0) && resp_i) blk_d = BLK_W'(RESP_DELAY);
    else if (blk_q != '0)           blk_d = blk_q - 1'b1;
    else                            blk_d = blk_q;

    for (int i = 0; i < NUM_REQ; i++) begin
      if (!complete_i[i] || granted[i])          age_d[i] = '0;
      else if (blocked)                          age_d[i] = age_q[i];
      else if (age_q[i] != AGE_W'(STARVE_LIMIT)) age_d[i] = age_q[i] + 1'b1;
      else                                       age_d[i] = age_q[i];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rr_q  <= '0;
      blk_q <= '0;
      age_q <= '0;
    end else begin
      rr_q  <= rr_d;
      blk_q <= blk_d;
      age_q <= age_d;
    end
  end

  assign grant_valid_o = rst_n ? gv : '0;
  assign grant_idx_o   = rst_n ? gi : '0;
  assign load_o        = rst_n & gv[0];

`ifdef CDB_ARB_STATS_EN
  logic [31:0] stat_grants_q, stat_block_q;
  logic [15:0] stat_starve_q;
  logic [32:0] grants_sum;

  assign grants_sum = {1'b0, stat_grants_q} + 33'($countones(gv));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stat_grants_q <= '0;
      stat_block_q  <= '0;
      stat_starve_q <= '0;
    end else begin
      stat_grants_q <= grants_sum[32] ? '1 : grants_sum[31:0];
      if (blocked && (|complete_i) && (stat_block_q != '1))
        stat_block_q <= stat_block_q + 1'b1;
      if (slot0_starve && (stat_starve_q != '1))
        stat_starve_q <= stat_starve_q + 1'b1;
    end
  end

  assign stat_grants_o       = stat_grants_q;
  assign stat_block_cycles_o = stat_block_q;
  assign stat_starve_o       = stat_starve_q;
`else
  logic unused_stats;
  assign unused_stats = slot0_starve;
`endif

endmodule

// File: tb/tb_cdb_arbiter.sv
module tb_cdb_arbiter;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  // Four arbiter configurations, each with its own input set.
  logic [7:0] c0 = '0, c1 = '0, c2 = '0;
  logic [4:0] c3 = '0;
  logic r0 = 1'b0, r1 = 1'b0, r2 = 1'b0, r3 = 1'b0;
  logic f0 = 1'b0, f1 = 1'b0, f2 = 1'b0, f3 = 1'b0;

  logic [1:0]      gv0, gv1, gv3;
  logic [0:0]      gv2;
  logic [1:0][2:0] gi0, gi1, gi3;
  logic [0:0][2:0] gi2;
  logic            ld0, ld1, ld2, ld3;

  // id 0: round robin, 8 req, 2 grants, resp delay 1
  cdb_arbiter #(.NUM_REQ(8), .NUM_GRANT(2), .ARB_MODE(1), .STARVE_LIMIT(7), .RESP_DELAY(1)) u_rr (
    .clk(clk), .rst_n(rst_n), .complete_i(c0), .resp_i(r0), .forward_i(f0),
    .grant_valid_o(gv0), .grant_idx_o(gi0), .load_o(ld0));

  // id 1: round robin, resp delay 3
  cdb_arbiter #(.NUM_REQ(8), .NUM_GRANT(2), .ARB_MODE(1), .STARVE_LIMIT(7), .RESP_DELAY(3)) u_rd3 (
    .clk(clk), .rst_n(rst_n), .complete_i(c1), .resp_i(r1), .forward_i(f1),
    .grant_valid_o(gv1), .grant_idx_o(gi1), .load_o(ld1));

  // id 2: fixed priority, single grant, starve limit 3
  cdb_arbiter #(.NUM_REQ(8), .NUM_GRANT(1), .ARB_MODE(0), .STARVE_LIMIT(3), .RESP_DELAY(1)) u_fp (
    .clk(clk), .rst_n(rst_n), .complete_i(c2), .resp_i(r2), .forward_i(f2),
    .grant_valid_o(gv2), .grant_idx_o(gi2), .load_o(ld2));

  // id 3: non-power-of-two request count
  cdb_arbiter #(.NUM_REQ(5), .NUM_GRANT(2), .ARB_MODE(1), .STARVE_LIMIT(7), .RESP_DELAY(1)) u_n5 (
    .clk(clk), .rst_n(rst_n), .complete_i(c3), .resp_i(r3), .forward_i(f3),
    .grant_valid_o(gv3), .grant_idx_o(gi3), .load_o(ld3));

  typedef struct {
    int         id;
    logic [1:0] gv;
    logic [2:0] i0;
    logic [2:0] i1;
    string      name;
  } exp_t;

  exp_t q[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  // Apply one cycle of stimulus to one instance and queue what it must show.
  task automatic step(input int id, input logic [7:0] c, input logic rs, input logic fw,
                      input logic rstv, input logic [1:0] egv, input logic [2:0] e0,
                      input logic [2:0] e1, input string name);
    exp_t e;
    @(posedge clk);
    #1;
    rst_n = rstv;
    case (id)
      0: begin c0 = c;      r0 = rs; f0 = fw; end
      1: begin c1 = c;      r1 = rs; f1 = fw; end
      2: begin c2 = c;      r2 = rs; f2 = fw; end
      default: begin c3 = c[4:0]; r3 = rs; f3 = fw; end
    endcase
    e.id = id; e.gv = egv; e.i0 = e0; e.i1 = e1; e.name = name;
    q.push_back(e);
  endtask

  // Monitor: pops expectations and compares against the selected instance.
  always @(negedge clk) begin
    exp_t       e;
    logic [1:0] agv;
    logic [2:0] a0, a1;
    logic       al;
    while (q.size() > 0) begin
      e = q.pop_front();
      case (e.id)
        0: begin agv = gv0; a0 = gi0[0]; a1 = gi0[1]; al = ld0; end
        1: begin agv = gv1; a0 = gi1[0]; a1 = gi1[1]; al = ld1; end
        2: begin agv = {1'b0, gv2}; a0 = gi2[0]; a1 = 3'd0; al = ld2; end
        default: begin agv = gv3; a0 = gi3[0]; a1 = gi3[1]; al = ld3; end
      endcase
      n_cmp++;
      if ({agv, a0, a1, al} !== {e.gv, e.i0, e.i1, e.gv[0]}) begin
        n_bad++;
        $display("FAIL %s: got gv=%b idx=%0d,%0d load=%b, expected gv=%b idx=%0d,%0d load=%b",
                 e.name, agv, a0, a1, al, e.gv, e.i0, e.i1, e.gv[0]);
      end
    end
  end

  initial begin
    // Reset held: outputs forced low even with every station complete.
    step(0, 8'hFF, 0, 0, 0, 2'b00, 0, 0, "reset_outputs");

    // Round robin over 1010_0110.
    step(0, 8'hA6, 0, 0, 1, 2'b11, 1, 2, "rr_c0");
    step(0, 8'hA6, 0, 0, 1, 2'b11, 5, 7, "rr_c1");
    step(0, 8'hA6, 0, 0, 1, 2'b11, 1, 2, "rr_c2");

    // Forward blocks three cycles; pointer (3) survives.
    step(0, 8'hFF, 0, 1, 1, 2'b00, 0, 0, "fwd_1");
    step(0, 8'hFF, 0, 1, 1, 2'b00, 0, 0, "fwd_2");
    step(0, 8'hFF, 0, 1, 1, 2'b00, 0, 0, "fwd_3");
    step(0, 8'hFF, 0, 0, 1, 2'b11, 3, 4, "fwd_resume");
    step(0, 8'hFF, 0, 0, 1, 2'b11, 5, 6, "fwd_resume2");
    step(0, 8'h00, 0, 0, 1, 2'b00, 0, 0, "no_complete");

    // Resp blackout of one cycle.
    step(0, 8'h01, 1, 0, 1, 2'b01, 0, 0, "rd1_t");
    step(0, 8'h01, 0, 0, 1, 2'b00, 0, 0, "rd1_t1");
    step(0, 8'h01, 0, 0, 1, 2'b01, 0, 0, "rd1_t2");
    step(0, 8'h00, 0, 0, 1, 2'b00, 0, 0, "rd1_idle");

    // Resp blackout of three cycles, then reload while blocked.
    step(1, 8'h01, 1, 0, 1, 2'b01, 0, 0, "rd3_t");
    step(1, 8'h01, 0, 0, 1, 2'b00, 0, 0, "rd3_t1");
    step(1, 8'h01, 0, 0, 1, 2'b00, 0, 0, "rd3_t2");
    step(1, 8'h01, 0, 0, 1, 2'b00, 0, 0, "rd3_t3");
    step(1, 8'h01, 0, 0, 1, 2'b01, 0, 0, "rd3_t4");
    step(1, 8'h01, 1, 0, 1, 2'b01, 0, 0, "rd3_resp_a");
    step(1, 8'h01, 1, 0, 1, 2'b00, 0, 0, "rd3_reload");
    step(1, 8'h01, 0, 0, 1, 2'b00, 0, 0, "rd3_ext1");
    step(1, 8'h01, 0, 0, 1, 2'b00, 0, 0, "rd3_ext2");
    step(1, 8'h01, 0, 0, 1, 2'b00, 0, 0, "rd3_ext3");
    step(1, 8'h01, 0, 0, 1, 2'b01, 0, 0, "rd3_ext_end");

    // Reset mid-window cancels the blackout.
    step(1, 8'h04, 1, 0, 1, 2'b01, 2, 0, "rst_win_resp");
    step(1, 8'h04, 0, 0, 0, 2'b00, 0, 0, "rst_win_low");
    step(1, 8'h04, 0, 0, 1, 2'b01, 2, 0, "rst_win_release");
    step(1, 8'h00, 0, 0, 1, 2'b00, 0, 0, "rst_win_idle");

    // Fixed priority with starvation override for station 7.
    step(2, 8'h81, 0, 0, 1, 2'b01, 0, 0, "starve_0");
    step(2, 8'h81, 0, 0, 1, 2'b01, 0, 0, "starve_1");
    step(2, 8'h81, 0, 0, 1, 2'b01, 0, 0, "starve_2");
    step(2, 8'h81, 0, 0, 1, 2'b01, 7, 0, "starve_3");
    step(2, 8'h81, 0, 0, 1, 2'b01, 0, 0, "starve_4");
    step(2, 8'h81, 0, 0, 1, 2'b01, 0, 0, "starve_5");
    step(2, 8'h81, 0, 0, 1, 2'b01, 0, 0, "starve_6");
    step(2, 8'h81, 0, 0, 1, 2'b01, 7, 0, "starve_7");
    step(2, 8'h00, 0, 0, 1, 2'b00, 0, 0, "starve_idle");

    // Five requesters: pointer wraps past index 4.
    step(3, 8'h11, 0, 0, 1, 2'b11, 0, 4, "n5_a");
    step(3, 8'h11, 0, 0, 1, 2'b11, 0, 4, "n5_b");
    step(3, 8'h18, 0, 0, 1, 2'b11, 3, 4, "n5_c");
    step(3, 8'h07, 0, 0, 1, 2'b11, 0, 1, "n5_d");
    step(3, 8'h17, 0, 0, 1, 2'b11, 2, 4, "n5_e");
    step(3, 8'h00, 0, 0, 1, 2'b00, 0, 0, "n5_idle");

    @(negedge clk);
    #1;
    n_cmp++;
    if (q.size() != 0) begin
      n_bad++;
      $display("FAIL drain: got %0d pending expectations, expected 0", q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
